// File: rtl/ipv_pkg.sv
// Shared constants and helpers for the multi-channel IPV reducer.
// Mode encodings and the counter/popcount width derivation live here.
package ipv_pkg;

  localparam logic IPV_MODE_THERM = 1'b0;
  localparam logic IPV_MODE_BIN   = 1'b1;

  // Width that holds a count of 0..k inclusive.
  function automatic int ipv_cw(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/ipv_lane.sv
// One IPV lane: folds a serial bit stream into a K-bit thermometer or
// binary occupancy value. acc_o is the post-beat value for the window-close capture.
module ipv_lane
  import ipv_pkg::*;
#(
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic         bit_i,
  input  logic         mode_i,
  output logic [K-1:0] acc_o
);

  localparam int CW = ipv_cw(K);

  logic [K-1:0] acc_q, acc_d, base;

  always_comb begin
    base  = load_i ? '0 : acc_q;
    acc_d = acc_q;
    if (en_i) begin
      acc_d = base;
      if (bit_i) begin
        if (mode_i == IPV_MODE_BIN) begin
          acc_d = K'(base[CW-1:0] + CW'(1));
        end else begin
          acc_d = {1'b1, base[K-1:1]};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_d;

endmodule

// File: rtl/ipv_reducer_mc.sv
// Multi-channel IPV reducer: per-lane K-beat windows with frame resync and
// abort, emitted through a fixed STALL-deep output pipeline.
module ipv_reducer_mc
  import ipv_pkg::*;
#(
  parameter int CH    = 4,
  parameter int K     = 4,
  parameter int STALL = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [CH-1:0]   ipv_in,
  input  logic            frame_start,
  input  logic            mode,
  output logic            out_valid,
  output logic [CH*K-1:0] vov,
  output logic            out_abort
);

  localparam int CW = ipv_cw(K);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic            abort_q, abort_d;
  logic            beat0, close, lane_mode;
  logic [CH*K-1:0] acc_nxt;

  logic [STALL-1:0] vld_q;
  logic [CH*K-1:0]  data_q [STALL];

  // A frame_start beat always restarts the window, even where it would close.
  always_comb begin
    beat0     = in_valid && (frame_start || cnt_q == '0);
    close     = in_valid && !frame_start && cnt_q == CW'(K - 1);
    abort_d   = in_valid && frame_start && cnt_q != '0;
    lane_mode = beat0 ? mode : mode_q;
    mode_d    = lane_mode;
    cnt_d     = cnt_q;
    if (in_valid) begin
      if (beat0) begin
        cnt_d = CW'(1);
      end else if (close) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_lane
    ipv_lane #(.K(K)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .load_i (beat0),
      .en_i   (in_valid),
      .bit_i  (ipv_in[g]),
      .mode_i (lane_mode),
      .acc_o  (acc_nxt[g*K +: K])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      mode_q  <= IPV_MODE_THERM;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      abort_q <= abort_d;
    end
  end

  // Output pipeline: stage 0 captures the closing window, later stages shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < STALL; i++) data_q[i] <= '0;
    end else begin
      vld_q[0]  <= close;
      data_q[0] <= close ? acc_nxt : '0;
      for (int i = 1; i < STALL; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[STALL-1];
  assign vov       = data_q[STALL-1];
  assign out_abort = abort_q;

endmodule

// File: tb/tb_ipv_reducer_mc.sv
// Directed bench for ipv_reducer_mc with CH=2, K=4, STALL=3.
module tb_ipv_reducer_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] ipv_in;
  logic       frame_start;
  logic       mode;
  logic       out_valid;
  logic [7:0] vov;
  logic       out_abort;

  int checks = 0;
  int errors = 0;

  ipv_reducer_mc #(.CH(2), .K(4), .STALL(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .ipv_in      (ipv_in),
    .frame_start (frame_start),
    .mode        (mode),
    .out_valid   (out_valid),
    .vov         (vov),
    .out_abort   (out_abort)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] b, input logic fs, input logic md);
    in_valid = 1'b1; ipv_in = b; frame_start = fs; mode = md;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0; ipv_in = 2'b00; frame_start = 1'b0;
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic a);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".vov"},   {24'd0, vov},       {24'd0, d});
    chk({tag, ".abort"}, {31'd0, out_abort}, {31'd0, a});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; ipv_in = 2'b00; frame_start = 1'b0; mode = 1'b0;
    tick(); tick();
    chk_out("reset", 1'b0, 8'h00, 1'b0);
    rst = 1'b0;

    // Thermometer, lane0 all ones.
    beat(2'b01, 0, 0); beat(2'b01, 0, 0); beat(2'b01, 0, 0); beat(2'b01, 0, 0);
    chk_out("therm.t0", 1'b0, 8'h00, 1'b0);
    idle(); chk_out("therm.t1", 1'b0, 8'h00, 1'b0);
    idle(); chk_out("therm.t2", 1'b1, 8'h0F, 1'b0);
    idle(); chk_out("therm.t3", 1'b0, 8'h00, 1'b0);

    // Binary popcount.
    beat(2'b11, 0, 1); beat(2'b10, 0, 1); beat(2'b11, 0, 1); beat(2'b00, 0, 1);
    idle(); chk_out("bin.t1", 1'b0, 8'h00, 1'b0);
    idle(); chk_out("bin.t2", 1'b1, 8'h32, 1'b0);
    idle(); chk_out("bin.t3", 1'b0, 8'h00, 1'b0);

    // Same with an in_valid gap before the last beat.
    beat(2'b11, 0, 1); beat(2'b10, 0, 1); beat(2'b11, 0, 1);
    repeat (5) idle();
    chk_out("gap.hold", 1'b0, 8'h00, 1'b0);
    beat(2'b00, 0, 1);
    idle(); chk_out("gap.t1", 1'b0, 8'h00, 1'b0);
    idle(); chk_out("gap.t2", 1'b1, 8'h32, 1'b0);
    idle(); chk_out("gap.t3", 1'b0, 8'h00, 1'b0);

    // frame_start at counter 2 aborts and restarts the window.
    beat(2'b11, 0, 0); beat(2'b11, 0, 0);
    beat(2'b01, 1, 0); chk_out("abort.pulse", 1'b0, 8'h00, 1'b1);
    beat(2'b01, 0, 0); chk_out("abort.end", 1'b0, 8'h00, 1'b0);
    beat(2'b00, 0, 0); chk_out("abort.noout", 1'b0, 8'h00, 1'b0);
    beat(2'b11, 0, 0);
    idle(); chk_out("resync.t1", 1'b0, 8'h00, 1'b0);
    idle(); chk_out("resync.t2", 1'b1, 8'h8E, 1'b0);
    idle();

    // mode is ignored mid-window.
    beat(2'b11, 0, 0); beat(2'b11, 0, 0); beat(2'b01, 0, 1); beat(2'b01, 0, 1);
    idle(); idle(); chk_out("modelatch.a", 1'b1, 8'hCF, 1'b0);
    beat(2'b11, 0, 1); beat(2'b11, 0, 1); beat(2'b01, 0, 0); beat(2'b01, 0, 0);
    idle(); idle(); chk_out("modelatch.b", 1'b1, 8'h24, 1'b0);
    idle();

    // Reset right after a window close kills the in-flight output.
    beat(2'b11, 0, 0); beat(2'b11, 0, 0); beat(2'b11, 0, 0); beat(2'b11, 0, 0);
    idle();
    rst = 1'b1; tick(); rst = 1'b0;
    chk_out("rst.kill", 1'b0, 8'h00, 1'b0);
    idle(); chk_out("rst.q1", 1'b0, 8'h00, 1'b0);
    idle(); chk_out("rst.q2", 1'b0, 8'h00, 1'b0);
    beat(2'b01, 0, 1); beat(2'b01, 0, 1); beat(2'b01, 0, 1); beat(2'b01, 0, 1);
    idle(); idle(); chk_out("rst.fresh", 1'b1, 8'h04, 1'b0);
    idle();

    // frame_start on the would-be closing beat: abort wins.
    beat(2'b00, 0, 0); beat(2'b00, 0, 0); beat(2'b00, 0, 0);
    in_valid = 1'b0; frame_start = 1'b1; tick();
    chk_out("fs.novalid", 1'b0, 8'h00, 1'b0);
    beat(2'b11, 1, 1); chk_out("fs.last.abort", 1'b0, 8'h00, 1'b1);
    beat(2'b11, 0, 0); chk_out("fs.last.t1", 1'b0, 8'h00, 1'b0);
    beat(2'b11, 0, 0); chk_out("fs.last.t2", 1'b0, 8'h00, 1'b0);
    beat(2'b11, 0, 0);
    idle(); idle(); chk_out("fs.last.win", 1'b1, 8'h44, 1'b0);
    idle();

    // frame_start at counter 0 is a plain beat 0.
    beat(2'b10, 1, 0); chk_out("fs.zero", 1'b0, 8'h00, 1'b0);
    beat(2'b10, 0, 0); beat(2'b10, 0, 0); beat(2'b10, 0, 0);
    idle(); idle(); chk_out("fs.zero.win", 1'b1, 8'hF0, 1'b0);
    idle(); chk_out("fs.zero.after", 1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ipv_reducer_mc.md
Name: ipv_reducer_mc

Overview:
Multi-channel successor to the single-lane IPV reducer. Each of CH lanes accumulates one serial IPV bit per accepted beat over a K-beat window. At window close, each lane emits a K-bit vote-occupancy vector (VOV) after a fixed STALL-cycle pipeline. It adds valid-gated input, frame resynchronisation and a selectable thermometer/binary output mode. It sits between the per-channel IPV generators and the downstream vote decoder.

Parameters:
CH, 4, number of independent IPV lanes
K, 4, window length in beats and VOV width per lane (2..16)
STALL, 3, output pipeline depth in cycles (>=1)
CW, $clog2(K+1), derived; counter/popcount width (localparam, not overridable)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  beat qualifier; state advances only when high
ipv_in  in  CH  one IPV bit per lane for the current beat
frame_start  in  1  qualified by in_valid; marks the current beat as beat 0 of a new window
mode  in  1  0 = thermometer, 1 = binary popcount; sampled at beat 0
out_valid  out  1  one-cycle pulse; vov carries a completed window
vov  out  CH*K  lane i in bits [i*K +: K]; all zero when out_valid is low
out_abort  out  1  one-cycle pulse; a partial window was discarded by frame_start

Behaviour:
- Reset (rst high at a clk edge):
  - beat counter = 0; all lane accumulators = 0; latched mode = 0.
  - All STALL pipeline stages: valid = 0, data = 0.
  - Outputs: out_valid = 0, vov = 0, out_abort = 0 from the following cycle.
  - rst mid-window or mid-pipeline discards everything; no output pulse for in-flight windows.
- Beat counter 0..K-1 advances only on in_valid=1 and wraps K-1 -> 0. When in_valid=0, counter, accumulators and latched mode hold.
- Beat 0 (counter==0, in_valid=1), or any in_valid beat with frame_start=1:
  - Accumulator loads the current beat's contribution from an empty state.
  - mode is latched. The mode input is ignored on all other beats.
- Accumulation per lane, beats 1..K-1:
  - Thermometer: bit=1 -> acc = {1'b1, acc[K-1:1]}; bit=0 -> hold. The result is MSB-aligned ones, count = number of 1 beats.
  - Binary: bit=1 -> acc = acc + 1, CW bits wide. No overflow is possible (max K). Output is zero-extended into K bits.
- Window close is the in_valid beat with counter==K-1 and frame_start=0.
  - The final accumulator, including that beat's bit, enters pipeline stage 0 with valid=1.
  - Latency: last beat accepted at edge t; out_valid=1 and vov valid in the cycle after edge t+STALL-1, i.e. STALL cycles after the beat.
- Non-closing cycles push valid=0, data=0 into stage 0. The pipeline shifts every cycle regardless of in_valid; there is no back-pressure.
- frame_start=1 with in_valid=1 and counter!=0:
  - The partial window is dropped and never output.
  - out_abort pulses on the next cycle (no pipeline delay).
  - The counter becomes 1, with the current beat counted as beat 0.
- frame_start=1 with counter==0: normal beat 0, no abort.
- frame_start=1 when the counter would otherwise close the window (counter==K-1): abort wins; no output for that window.
- frame_start with in_valid=0 is ignored.
- Back-to-back windows: out_valid may be high on consecutive cycles only if K=1 (disallowed by K>=2). Minimum spacing is K cycles.

Decomposition:
- Shared package ipv_pkg:
  - Mode constants IPV_MODE_THERM=1'b0 and IPV_MODE_BIN=1'b1.
  - A function computing CW from K.
- Sub-module ipv_lane (one per channel, generate loop):
  - Holds the K-bit accumulator.
  - Inputs: load, enable, bit, mode.
- Beat counter, abort logic and the STALL pipeline stay in the top level.

Test Plan (CH=2, K=4, STALL=3 unless noted):
- Reset then ipv_in=2'b01 for 4 valid beats, mode=0 -> 3 cycles after 4th beat out_valid=1 for one cycle, vov=8'b0000_1111; vov=0 otherwise.
- Lane0 bits 1,0,1,0 and lane1 bits 1,1,1,0, mode=1 -> vov[3:0]=4'd2, vov[7:4]=4'd3.
- Same stimulus with in_valid low for 5 cycles between beats 2 and 3 -> identical vov; out_valid exactly 3 cycles after the final valid beat.
- frame_start on beat 2 (counter==2) -> out_abort pulse next cycle, no out_valid for that window. The next window counts from that beat and closes 3 valid beats later.
- mode toggled to 1 on beat 2 of a mode=0 window -> output still thermometer; the next window (mode=1 at beat 0) outputs binary.
- rst asserted 1 cycle after a window close -> out_valid never fires for it; all outputs 0 until a fresh full window completes.
